mem_port_arbiter: RTL and testbench

- Sequences a single-ported unified instruction/data memory that is shared by the IF stage (fetch) and the MEM stage (load/store) of the 5-stage RISC-V pipeline.
- Accepts level requests from both ports and issues one memory transaction at a time.
- Waits a fixed memory latency, returns read data with a one-cycle ack pulse, and drives per-stage stall lines to the pipeline registers.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, port owners
// and the round-robin pick used when fetch and data requests collide.
package pipeline_pkg;

    localparam int LAT_CNT_W = 4;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;

    // On a collision the port that was not served last wins.
    function automatic owner_t rr_pick(input logic elig_if, input logic elig_dm,
                                       input owner_t last_owner);
        if (elig_if && elig_dm)
            return (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
        return elig_dm ? OWN_DM : OWN_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Sequences one single-ported memory shared by the IF and MEM pipeline stages:
// one transaction at a time, fixed latency, one-cycle ack, per-stage stalls.
module mem_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

    state_t               state;
    logic [LAT_CNT_W-1:0] cnt;
    owner_t               owner;
    owner_t               last_owner;
    logic                 cur_store;
    logic                 elig_if;
    logic                 elig_dm;
    owner_t               pick;

    // A port is never re-granted in its own ack cycle.
    assign elig_if = if_req & ~if_ack;
    assign elig_dm = dm_req & ~dm_ack;
    assign pick    = rr_pick(elig_if, elig_dm, last_owner);

    // Stalls are gated by reset so every output reads 0 while reset is held.
    assign stall_if  = reset & if_req & ~if_ack;
    assign stall_mem = reset & dm_req & ~dm_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            cur_store  <= 1'b0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (elig_if || elig_dm) begin
                        state      <= ST_BUSY;
                        cnt        <= LAT_INIT;
                        owner      <= pick;
                        last_owner <= pick;
                        mem_en     <= 1'b1;
                        if (pick == OWN_DM) begin
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            cur_store <= dm_we;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            cur_store <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    // Count 1 marks the cycle in which mem_rdata is valid.
                    if (cnt == CNT_ONE) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        if (owner == OWN_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            dm_ack <= 1'b1;
                            if (!cur_store)
                                dm_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random-traffic bench for mem_port_arbiter at MEM_LAT=1 and MEM_LAT=3, checked
// cycle by cycle against a transaction-level model of grants, issues and acks.
module tb_mem_port_arbiter;

    localparam int LAT_A  = 1;
    localparam int LAT_B  = 3;
    localparam int N_CYC  = 900;
    localparam int REL_0  = 3;
    localparam int RST_A  = 300;
    localparam int REL_A  = 303;
    localparam int RST_B  = 601;
    localparam int REL_B  = 602;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req[2];
    logic [31:0] if_addr[2];
    logic        if_ack[2];
    logic [31:0] if_rdata[2];
    logic        dm_req[2];
    logic        dm_we[2];
    logic [31:0] dm_addr[2];
    logic [31:0] dm_wdata[2];
    logic        dm_ack[2];
    logic [31:0] dm_rdata[2];
    logic        stall_if[2];
    logic        stall_mem[2];
    logic        mem_en[2];
    logic        mem_we[2];
    logic [31:0] mem_addr[2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata[2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state, per DUT d and per port p (0 = IF, 1 = DM).
    int          ack_cyc[2][2];
    logic        ack_now[2][2];
    int          issue_cyc[2];
    int          sample_cyc[2];
    int          free_at[2];
    int          last[2];
    int          rq_st[2][2];
    logic [31:0] sample_val[2];
    logic [31:0] iss_addr[2];
    logic [31:0] iss_wdata[2];
    logic        iss_we[2];
    logic [31:0] ld_data[2][2];
    logic        ld_valid[2];
    logic [31:0] exp_rd[2][2];
    logic [31:0] mem_m[2][64];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
        .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
        .dm_ack(dm_ack[0]), .dm_rdata(dm_rdata[0]),
        .stall_if(stall_if[0]), .stall_mem(stall_mem[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_B)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
        .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
        .dm_ack(dm_ack[1]), .dm_rdata(dm_rdata[1]),
        .stall_if(stall_if[1]), .stall_mem(stall_mem[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 255));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            issue_cyc[d]  = -1;
            sample_cyc[d] = -1;
            free_at[d]    = 0;
            last[d]       = 0;
            ld_valid[d]   = 1'b0;
            if_req[d]     = 1'b0;
            if_addr[d]    = '0;
            dm_req[d]     = 1'b0;
            dm_we[d]      = 1'b0;
            dm_addr[d]    = '0;
            dm_wdata[d]   = '0;
            for (int p = 0; p < 2; p++) begin
                ack_cyc[d][p] = -1;
                ack_now[d][p] = 1'b0;
                rq_st[d][p]   = 0;
                exp_rd[d][p]  = '0;
                ld_data[d][p] = '0;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s L%0d if_ack", tag, lat_of(d)), 32'(if_ack[d]), 32'd0);
            check($sformatf("%s L%0d if_rdata", tag, lat_of(d)), if_rdata[d], 32'd0);
            check($sformatf("%s L%0d dm_ack", tag, lat_of(d)), 32'(dm_ack[d]), 32'd0);
            check($sformatf("%s L%0d dm_rdata", tag, lat_of(d)), dm_rdata[d], 32'd0);
            check($sformatf("%s L%0d stall_if", tag, lat_of(d)), 32'(stall_if[d]), 32'd0);
            check($sformatf("%s L%0d stall_mem", tag, lat_of(d)), 32'(stall_mem[d]), 32'd0);
            check($sformatf("%s L%0d mem_en", tag, lat_of(d)), 32'(mem_en[d]), 32'd0);
            check($sformatf("%s L%0d mem_we", tag, lat_of(d)), 32'(mem_we[d]), 32'd0);
            check($sformatf("%s L%0d mem_addr", tag, lat_of(d)), mem_addr[d], 32'd0);
            check($sformatf("%s L%0d mem_wdata", tag, lat_of(d)), mem_wdata[d], 32'd0);
        end
    endtask

    task automatic check_outputs(input int d);
        logic en;
        ack_now[d][0] = (ack_cyc[d][0] == cyc);
        ack_now[d][1] = (ack_cyc[d][1] == cyc);
        if (ack_now[d][0]) exp_rd[d][0] = ld_data[d][0];
        if (ack_now[d][1] && ld_valid[d]) exp_rd[d][1] = ld_data[d][1];
        en = (issue_cyc[d] == cyc);
        check($sformatf("L%0d if_ack", lat_of(d)), 32'(if_ack[d]), 32'(ack_now[d][0]));
        check($sformatf("L%0d dm_ack", lat_of(d)), 32'(dm_ack[d]), 32'(ack_now[d][1]));
        check($sformatf("L%0d if_rdata", lat_of(d)), if_rdata[d], exp_rd[d][0]);
        check($sformatf("L%0d dm_rdata", lat_of(d)), dm_rdata[d], exp_rd[d][1]);
        check($sformatf("L%0d stall_if", lat_of(d)), 32'(stall_if[d]),
              32'(if_req[d] && !ack_now[d][0]));
        check($sformatf("L%0d stall_mem", lat_of(d)), 32'(stall_mem[d]),
              32'(dm_req[d] && !ack_now[d][1]));
        check($sformatf("L%0d mem_en", lat_of(d)), 32'(mem_en[d]), 32'(en));
        check($sformatf("L%0d mem_we", lat_of(d)), 32'(mem_we[d]), 32'(en && iss_we[d]));
        if (en) check($sformatf("L%0d mem_addr", lat_of(d)), mem_addr[d], iss_addr[d]);
        if (en && iss_we[d])
            check($sformatf("L%0d mem_wdata", lat_of(d)), mem_wdata[d], iss_wdata[d]);
    endtask

    // Protocol-abiding requesters: hold until ack, may drop only while in flight.
    task automatic requesters(input int d);
        for (int p = 0; p < 2; p++) begin
            logic a;
            logic in_flight;
            logic r;
            a = ack_now[d][p];
            in_flight = (ack_cyc[d][p] > cyc);
            r = 1'b0;
            case (rq_st[d][p])
                1: begin
                    if (a) begin
                        if ($urandom_range(0, 1) == 1) r = 1'b1;
                        else rq_st[d][p] = 0;
                    end else if (in_flight && $urandom_range(0, 15) == 0) begin
                        rq_st[d][p] = 2;
                    end
                end
                2: if (a) rq_st[d][p] = 0;
                default: if ($urandom_range(0, 2) == 0) begin
                    rq_st[d][p] = 1;
                    r = 1'b1;
                end
            endcase
            if (p == 0) begin
                if_req[d] = (rq_st[d][0] == 1);
                if (r) if_addr[d] = rand_addr();
            end else begin
                dm_req[d] = (rq_st[d][1] == 1);
                if (r) begin
                    dm_we[d]    = 1'($urandom_range(0, 1));
                    dm_addr[d]  = rand_addr();
                    dm_wdata[d] = $urandom;
                end
            end
        end
    endtask

    // Grant rule: free memory, eligible = req and not acked now, round-robin on tie.
    task automatic decide(input int d);
        logic e_if;
        logic e_dm;
        int   w;
        if (cyc < free_at[d]) return;
        e_if = if_req[d] && !ack_now[d][0];
        e_dm = dm_req[d] && !ack_now[d][1];
        if (!(e_if || e_dm)) return;
        if (e_if && e_dm) w = (last[d] == 0) ? 1 : 0;
        else w = e_dm ? 1 : 0;
        last[d]       = w;
        issue_cyc[d]  = cyc + 1;
        sample_cyc[d] = cyc + lat_of(d);
        ack_cyc[d][w] = cyc + lat_of(d) + 1;
        free_at[d]    = cyc + lat_of(d) + 1;
        if (w == 0) begin
            iss_addr[d]   = if_addr[d];
            iss_we[d]     = 1'b0;
            ld_data[d][0] = mem_m[d][if_addr[d][7:2]];
            sample_val[d] = ld_data[d][0];
        end else begin
            iss_addr[d]  = dm_addr[d];
            iss_we[d]    = dm_we[d];
            iss_wdata[d] = dm_wdata[d];
            if (dm_we[d]) begin
                mem_m[d][dm_addr[d][7:2]] = dm_wdata[d];
                ld_valid[d]   = 1'b0;
                sample_val[d] = $urandom;
            end else begin
                ld_data[d][1] = mem_m[d][dm_addr[d][7:2]];
                ld_valid[d]   = 1'b1;
                sample_val[d] = ld_data[d][1];
            end
        end
    endtask

    initial begin
        model_clear();
        for (int d = 0; d < 2; d++) begin
            mem_rdata[d] = '0;
            for (int i = 0; i < 64; i++) mem_m[d][i] = $urandom;
            mem_m[d][4]  = 32'h0040_0093;
            mem_m[d][17] = 32'h1234_5678;
        end
        for (int c = 1; c <= N_CYC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            // Memory presents valid data only in the sample cycle; garbage otherwise.
            for (int d = 0; d < 2; d++)
                mem_rdata[d] = (cyc == sample_cyc[d]) ? sample_val[d] : $urandom;
            if (cyc == RST_A || cyc == RST_B) begin
                #2;
                reset = 1'b0;
                model_clear();
                #1;
                check_zero("async_rst");
            end
            @(negedge clk);
            if (!reset) begin
                check_zero("rst");
                if (cyc == REL_0 || cyc == REL_A || cyc == REL_B) reset = 1'b1;
                else continue;
            end
            for (int d = 0; d < 2; d++) begin
                check_outputs(d);
                if (cyc == REL_0) begin
                    if_req[d]   = 1'b1;
                    if_addr[d]  = 32'h0000_0010;
                    dm_req[d]   = 1'b1;
                    dm_we[d]    = 1'b1;
                    dm_addr[d]  = 32'h0000_0020;
                    dm_wdata[d] = 32'hDEAD_BEEF;
                    rq_st[d][0] = 1;
                    rq_st[d][1] = 1;
                end else begin
                    requesters(d);
                end
                decide(d);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
